// File: rtl/axil_pkg.sv
// ----------------------------------------------------------------------------
// axil_pkg
// Shared AXI-Lite encodings and the LSU master's state and control types.
//   RESP_*   : AXI-Lite rresp/bresp codes
//   SIZE_*   : core request size codes (byte, half, word, illegal)
//   lsu_state_e : LSU master FSM states
//   lsu_ctl_t   : per-request control latched at acceptance
// ----------------------------------------------------------------------------
package axil_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] SIZE_B   = 2'd0;
   localparam logic [1:0] SIZE_H   = 2'd1;
   localparam logic [1:0] SIZE_W   = 2'd2;
   localparam logic [1:0] SIZE_ILL = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RESP
   } lsu_state_e;

   typedef struct packed {
      logic [1:0] size;
      logic       sgn;
   } lsu_ctl_t;

endpackage

// File: rtl/axil_lsu_align.sv
// ----------------------------------------------------------------------------
// axil_lsu_align
// Combinational byte-lane steering for the LSU master.
//   Store side: req_off/st_size/st_data -> st_wdata_c, st_wstrb_c, misalign_c
//   Load side : ld_off/ld_size/ld_signed/ld_raw -> ld_data_c (extended)
// ----------------------------------------------------------------------------
module axil_lsu_align
   import axil_pkg::*;
(
   input  logic [1:0]        req_off,
   input  logic [1:0]        st_size,
   input  logic [DATA_W-1:0] st_data,
   output logic [DATA_W-1:0] st_wdata_c,
   output logic [STRB_W-1:0] st_wstrb_c,
   output logic              misalign_c,
   input  logic [1:0]        ld_off,
   input  logic [1:0]        ld_size,
   input  logic              ld_signed,
   input  logic [DATA_W-1:0] ld_raw,
   output logic [DATA_W-1:0] ld_data_c
);

   logic [STRB_W-1:0] strb_base;
   logic [DATA_W-1:0] ld_shift;

   // Store lanes: data and strobe move up by the byte offset
   always_comb begin
      strb_base  = '0;
      misalign_c = 1'b0;
      case (st_size)
         SIZE_B: strb_base = STRB_W'(4'b0001);
         SIZE_H: begin
            strb_base  = STRB_W'(4'b0011);
            misalign_c = req_off[0];
         end
         SIZE_W: begin
            strb_base  = STRB_W'(4'b1111);
            misalign_c = (req_off != 2'd0);
         end
         default: ;
      endcase
      st_wdata_c = st_data << {req_off, 3'b000};
      st_wstrb_c = strb_base << req_off;
   end

   // Load lanes: bring the addressed bytes down to bit 0, then extend
   always_comb begin
      ld_shift = ld_raw >> {ld_off, 3'b000};
      case (ld_size)
         SIZE_B:  ld_data_c = ld_signed ? {{24{ld_shift[7]}}, ld_shift[7:0]}
                                        : {24'd0, ld_shift[7:0]};
         SIZE_H:  ld_data_c = ld_signed ? {{16{ld_shift[15]}}, ld_shift[15:0]}
                                        : {16'd0, ld_shift[15:0]};
         default: ld_data_c = ld_shift;
      endcase
   end

endmodule

// File: rtl/axil_lsu_master.sv
// ----------------------------------------------------------------------------
// axil_lsu_master
// AXI-Lite initiator for the load/store unit: one core request at a time,
// one AXI-Lite read or write per request, one response per request.
//   clk, rst           : clock, async active-high reset
//   req_*              : core request (valid/ready handshake)
//   resp_*             : core response (held until resp_ready)
//   ar*/r*/aw*/w*/b*   : AXI-Lite master channels
// Optional build macro AXIL_LSU_PERF_EN adds perf_ld_cnt, perf_st_cnt and
// perf_stall_cnt (PERF_W bits each).
// ----------------------------------------------------------------------------
module axil_lsu_master
   import axil_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
`ifdef AXIL_LSU_PERF_EN
  ,parameter int unsigned PERF_W = 32
`endif
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready,
   output logic [ADDR_W-1:0] awaddr,
   output logic              awvalid,
   input  logic              awready,
   output logic [DATA_W-1:0] wdata,
   output logic [STRB_W-1:0] wstrb,
   output logic              wvalid,
   input  logic              wready,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready
`ifdef AXIL_LSU_PERF_EN
  ,output logic [PERF_W-1:0] perf_ld_cnt
  ,output logic [PERF_W-1:0] perf_st_cnt
  ,output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

   lsu_state_e        state;
   logic [ADDR_W-1:0] addr_q;
   lsu_ctl_t          ctl_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        rsp_q;
   logic              cap_q;     // bus response captured; move to RESP next edge
   logic              aw_done;
   logic              w_done;

   logic [DATA_W-1:0] st_wdata_c;
   logic [STRB_W-1:0] st_wstrb_c;
   logic              misalign_c;
   logic [DATA_W-1:0] ld_data_c;
   logic              aw_fin_c;
   logic              w_fin_c;

   axil_lsu_align u_align (
      .req_off    (req_addr[1:0]),
      .st_size    (req_size),
      .st_data    (req_wdata),
      .st_wdata_c (st_wdata_c),
      .st_wstrb_c (st_wstrb_c),
      .misalign_c (misalign_c),
      .ld_off     (addr_q[1:0]),
      .ld_size    (ctl_q.size),
      .ld_signed  (ctl_q.sgn),
      .ld_raw     (rdata_q),
      .ld_data_c  (ld_data_c)
   );

   assign araddr = addr_q;
   assign awaddr = addr_q;

   // A write channel counts as finished if done earlier or handshaking now
   always_comb begin
      aw_fin_c = aw_done | (awvalid & awready);
      w_fin_c  = w_done  | (wvalid  & wready);
   end

   // Transaction FSM with registered bus and response outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         req_ready  <= 1'b1;
         addr_q     <= '0;
         ctl_q      <= '0;
         rdata_q    <= '0;
         rsp_q      <= RESP_OKAY;
         cap_q      <= 1'b0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         arvalid    <= 1'b0;
         rready     <= 1'b0;
         awvalid    <= 1'b0;
         wvalid     <= 1'b0;
         wdata      <= '0;
         wstrb      <= '0;
         bready     <= 1'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  addr_q     <= req_addr;
                  ctl_q.size <= req_size;
                  ctl_q.sgn  <= req_signed;
                  req_ready  <= 1'b0;
                  cap_q      <= 1'b0;
                  aw_done    <= 1'b0;
                  w_done     <= 1'b0;
                  if (misalign_c || (req_size == SIZE_ILL)) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else if (req_we) begin
                     state   <= ST_WR_REQ;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                     wdata   <= st_wdata_c;
                     wstrb   <= st_wstrb_c;
                  end else begin
                     state   <= ST_RD_ADDR;
                     arvalid <= 1'b1;
                  end
               end
            end
            ST_RD_ADDR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= ST_RD_DATA;
               end
            end
            ST_RD_DATA: begin
               if (cap_q) begin
                  state      <= ST_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= (rsp_q != RESP_OKAY);
                  resp_rdata <= ld_data_c;
               end else if (rvalid) begin
                  rready  <= 1'b0;
                  rdata_q <= rdata;
                  rsp_q   <= rresp;
                  cap_q   <= 1'b1;
               end
            end
            ST_WR_REQ: begin
               if (awvalid && awready) begin
                  awvalid <= 1'b0;
                  aw_done <= 1'b1;
               end
               if (wvalid && wready) begin
                  wvalid <= 1'b0;
                  w_done <= 1'b1;
               end
               if (aw_fin_c && w_fin_c) begin
                  state  <= ST_WR_RESP;
                  bready <= 1'b1;
               end
            end
            ST_WR_RESP: begin
               if (cap_q) begin
                  state      <= ST_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= (rsp_q != RESP_OKAY);
                  resp_rdata <= '0;
               end else if (bvalid) begin
                  bready <= 1'b0;
                  rsp_q  <= bresp;
                  cap_q  <= 1'b1;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state      <= ST_IDLE;
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

`ifdef AXIL_LSU_PERF_EN
   // Completed bus transfers and busy cycles, wrapping naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_ld_cnt    <= '0;
         perf_st_cnt    <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if ((state != ST_IDLE) && (state != ST_RESP))
            perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
         if ((state == ST_RD_DATA) && cap_q)
            perf_ld_cnt <= perf_ld_cnt + PERF_W'(1);
         if ((state == ST_WR_RESP) && cap_q)
            perf_st_cnt <= perf_st_cnt + PERF_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_axil_lsu_master.sv
// ----------------------------------------------------------------------------
// tb_axil_lsu_master
// Drives core requests and plays an AXI-Lite slave with per-channel delays;
// expected response data, lanes, strobes, latency and handshake counts come
// from a byte-level reference model of load/store behaviour.
// ----------------------------------------------------------------------------
module tb_axil_lsu_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_signed;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] araddr, awaddr, rdata, wdata;
   logic        arvalid, arready, rvalid, rready;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [1:0]  rresp, bresp;
   logic [3:0]  wstrb;

   int    n_cmp = 0;
   int    n_bad = 0;
   string cur   = "init";

   always #5 clk = ~clk;

   axil_lsu_master dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_signed(req_signed),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL [%s] %s: got 0x%08h expected 0x%08h", cur, tag, obs, exp);
      end
   endtask

   // Reference: pick nb bytes starting at byte off, then extend
   function automatic logic [31:0] ref_load(input logic [31:0] raw, input int off,
                                            input int nb, input logic sgn);
      logic [31:0] v;
      logic [31:0] mask;
      v = raw >> (8 * off);
      if (nb < 4) begin
         mask = (32'd1 << (8 * nb)) - 32'd1;
         v    = v & mask;
         if (sgn && v[8*nb-1]) v = v | ~mask;
      end
      return v;
   endfunction

   task automatic run_txn(input string nm, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input int size, input logic sgn,
                          input logic [31:0] sl_rdata, input logic [1:0] sl_resp,
                          input int ar_dly, input int r_dly, input int aw_dly,
                          input int w_dly, input int b_dly, input int rr_dly);
      int          nb, off, exp_lat, lat, hold, viol;
      int          n_ar, n_r, n_aw, n_w, n_b;
      int          ar_cyc, aw_cyc, w_cyc, wr_last;
      logic        legal, exp_err, released, finished;
      logic [31:0] exp_rd, exp_wd;
      logic [3:0]  exp_strb;

      cur = nm;
      nb  = 1 << size;
      off = int'(addr[1:0]);
      legal    = (size != 3) && ((off % nb) == 0);
      exp_err  = !legal || (sl_resp != 2'b00);
      exp_rd   = (legal && !we) ? ref_load(sl_rdata, off, nb, sgn) : 32'd0;
      exp_wd   = wd << (8 * off);
      exp_strb = 4'(((1 << nb) - 1) << off);
      if (!legal)  exp_lat = 0;
      else if (we) exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
      else         exp_lat = 3 + ar_dly + r_dly;

      n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
      ar_cyc = -1; aw_cyc = -1; w_cyc = -1;
      lat = -1; hold = 0; viol = 0;
      released = 1'b0; finished = 1'b0;

      @(negedge clk);
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_wdata  = wd;
      req_size   = 2'(size);
      req_signed = sgn;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;

      for (int c = 0; c < 80 && !finished; c++) begin
         if (c > 0) @(negedge clk);
         if (released) begin
            check("resp_valid_drop", 32'(resp_valid), 32'd0);
            check("req_ready_back", 32'(req_ready), 32'd1);
            resp_ready = 1'b0;
            finished   = 1'b1;
         end else begin
            if (arvalid && (awvalid || wvalid)) viol++;
            arready = (c >= ar_dly);
            awready = (c >= aw_dly);
            wready  = (c >= w_dly);
            if (arvalid && arready) begin
               n_ar++;
               ar_cyc = c;
               check("araddr", araddr, addr);
            end
            if (n_r > 0) rvalid = 1'b0;
            else if (ar_cyc >= 0 && (c - ar_cyc - 1) >= r_dly) begin
               rvalid = 1'b1;
               rdata  = sl_rdata;
               rresp  = sl_resp;
            end
            if (rvalid && rready) n_r++;
            // A finished write channel must stay low while the other is pending
            if (w_cyc >= 0 && w_cyc < c && aw_cyc < 0 && !(!wvalid && awvalid)) viol++;
            if (aw_cyc >= 0 && aw_cyc < c && w_cyc < 0 && !(!awvalid && wvalid)) viol++;
            if (awvalid && awready) begin
               n_aw++;
               aw_cyc = c;
               check("awaddr", awaddr, addr);
            end
            if (wvalid && wready) begin
               n_w++;
               w_cyc = c;
               check("wdata", wdata, exp_wd);
               check("wstrb", 32'(wstrb), 32'(exp_strb));
            end
            wr_last = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
            if (n_b > 0) bvalid = 1'b0;
            else if (aw_cyc >= 0 && w_cyc >= 0 && (c - wr_last - 1) >= b_dly) begin
               bvalid = 1'b1;
               bresp  = sl_resp;
            end
            if (bvalid && bready) n_b++;
            if (resp_valid) begin
               if (lat < 0) begin
                  lat = c;
                  check("latency", 32'(lat), 32'(exp_lat));
               end
               check("resp_rdata", resp_rdata, exp_rd);
               check("resp_err", 32'(resp_err), 32'(exp_err));
               if (hold >= rr_dly) begin
                  resp_ready = 1'b1;
                  released   = 1'b1;
               end else begin
                  hold++;
               end
            end
         end
      end
      if (!finished) check("timeout", 32'd1, 32'd0);
      check("n_ar", 32'(n_ar), (legal && !we) ? 32'd1 : 32'd0);
      check("n_r",  32'(n_r),  (legal && !we) ? 32'd1 : 32'd0);
      check("n_aw", 32'(n_aw), (legal && we)  ? 32'd1 : 32'd0);
      check("n_w",  32'(n_w),  (legal && we)  ? 32'd1 : 32'd0);
      check("n_b",  32'(n_b),  (legal && we)  ? 32'd1 : 32'd0);
      check("protocol", 32'(viol), 32'd0);
      arready = 1'b0; awready = 1'b0; wready = 1'b0;
      rvalid = 1'b0; bvalid = 1'b0; resp_ready = 1'b0;
   endtask

   initial begin
      int size, dsel;
      logic [1:0] sresp;

      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_size = '0; req_signed = 1'b0; resp_ready = 1'b0;
      arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0;
      awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;

      repeat (2) @(negedge clk);
      cur = "reset";
      check("rst_arvalid", 32'(arvalid), 32'd0);
      check("rst_awvalid", 32'(awvalid), 32'd0);
      check("rst_wvalid", 32'(wvalid), 32'd0);
      check("rst_rready", 32'(rready), 32'd0);
      check("rst_bready", 32'(bready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      rst = 1'b0;

      run_txn("ld_word", 1'b0, 32'h8000_0004, 32'd0, 2, 1'b0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, 0);
      run_txn("ld_byte_s", 1'b0, 32'h8000_0003, 32'd0, 0, 1'b1, 32'h80FF_FFFF, 2'b00, 0, 0, 0, 0, 0, 0);
      run_txn("ld_byte_u", 1'b0, 32'h8000_0003, 32'd0, 0, 1'b0, 32'h80FF_FFFF, 2'b00, 1, 2, 0, 0, 0, 1);
      run_txn("st_half", 1'b1, 32'h8000_0002, 32'h0000_1234, 1, 1'b0, 32'd0, 2'b00, 0, 0, 2, 0, 0, 0);
      run_txn("st_word0", 1'b1, 32'h8000_0010, 32'hCAFE_F00D, 2, 1'b0, 32'd0, 2'b00, 0, 0, 0, 0, 0, 0);
      run_txn("ld_misal", 1'b0, 32'h8000_0001, 32'd0, 2, 1'b0, 32'h1234_5678, 2'b00, 0, 0, 0, 0, 0, 0);
      run_txn("st_illegal", 1'b1, 32'h8000_0000, 32'h1111_1111, 3, 1'b0, 32'd0, 2'b00, 0, 0, 0, 0, 0, 2);
      run_txn("st_slverr", 1'b1, 32'h8000_0008, 32'hA5A5_A5A5, 2, 1'b0, 32'd0, 2'b10, 0, 0, 1, 1, 0, 3);
      run_txn("ld_half_s", 1'b0, 32'h8000_0006, 32'd0, 1, 1'b1, 32'h9ABC_1234, 2'b11, 0, 1, 0, 0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         size  = int'($urandom_range(0, 3));
         dsel  = int'($urandom_range(0, 3));
         sresp = (dsel == 0) ? 2'($urandom) : 2'b00;
         run_txn($sformatf("rand%0d", i), 1'($urandom), $urandom, $urandom, size,
                 1'($urandom), $urandom, sresp,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end

      // Abandon a load while it waits for read data
      cur = "rst_in_rd_data";
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0010;
      req_size = 2'd2; req_signed = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      arready   = 1'b1;
      for (int i = 0; i < 10 && !rready; i++) @(negedge clk);
      check("rready_before_rst", 32'(rready), 32'd1);
      arready = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_mid_arvalid", 32'(arvalid), 32'd0);
      check("rst_mid_rready", 32'(rready), 32'd0);
      check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_mid_req_ready", 32'(req_ready), 32'd1);

      run_txn("after_rst", 1'b0, 32'h8000_0002, 32'd0, 1, 1'b1, 32'h8001_7FFF, 2'b00, 0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
